// File: rtl/onchip_mem_stream_loader_pkg.sv
// Shared types and helpers for the byte-stream loader into the 1024x32 on-chip memory.
package onchip_mem_stream_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StFinish
  } state_e;

  localparam int unsigned NumLanes = 4;

  // Lane a byte lands in, given how many bytes of the current word are already held.
  function automatic logic [1:0] lane_idx(input int unsigned byte_cnt);
    return 2'(byte_cnt % NumLanes);
  endfunction

endpackage

// File: rtl/onchip_mem_byte_packer.sv
// Little-endian byte-to-word packer: lane buffer, byteenable accumulation and word-complete flag.
module onchip_mem_byte_packer
  import onchip_mem_stream_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        last_i,
  input  logic [7:0]  data_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  output logic        word_done_o
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane;

  always_comb begin
    lane   = lane_idx(32'(cnt_q));
    cnt_d  = cnt_q;
    data_d = data_q;
    be_d   = be_q;
    if (clear_i) begin
      cnt_d  = '0;
      data_d = '0;
      be_d   = '0;
    end else if (push_i) begin
      data_d[{lane, 3'b000} +: 8] = data_i;
      be_d[lane]                  = 1'b1;
      cnt_d                       = cnt_q + 3'd1;
    end
  end

  // Asserted with the byte that completes the word, so the FSM enters WRITE on the next edge.
  assign word_done_o = push_i & ((cnt_q == 3'(NumLanes - 1)) | last_i);
  assign data_o      = data_q;
  assign be_o        = be_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      be_q   <= be_d;
    end
  end

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Loads a host byte stream into on-chip memory as packed 32-bit Avalon-MM writes.
module onchip_mem_stream_loader
  import onchip_mem_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [7:0]        st_data,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned SpanW = ((ADDR_W + 2 > LEN_W) ? ADDR_W + 2 : LEN_W) + 1;
  localparam logic [SpanW-1:0] SpanMax = SpanW'(NumLanes << ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              err_q, err_d;
  logic              init_q;

  logic              out_en;
  logic              cmd_take, st_take;
  logic              pack_clear, word_done;
  logic [31:0]       pack_data;
  logic [3:0]        pack_be;
  logic [SpanW-1:0]  span;
  logic              range_bad;

  onchip_mem_byte_packer u_packer (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (pack_clear),
    .push_i      (st_take),
    .last_i      (rem_q == LEN_W'(1)),
    .data_i      (st_data),
    .data_o      (pack_data),
    .be_o        (pack_be),
    .word_done_o (word_done)
  );

  assign span      = SpanW'({cmd_base, 2'b00}) + SpanW'(cmd_len);
  assign range_bad = span > SpanMax;

  // Outputs are forced low while reset is high and for one cycle after it.
  assign out_en    = ~reset & ~init_q;
  assign cmd_take  = cmd_valid & cmd_ready;
  assign st_take   = st_valid & st_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    pack_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_take) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            state_d = StFinish;
          end else begin
            addr_d     = cmd_base;
            rem_d      = cmd_len;
            pack_clear = 1'b1;
            state_d    = StCollect;
          end
        end
      end
      StCollect: begin
        if (st_take) begin
          rem_d = rem_q - LEN_W'(1);
          if (word_done) state_d = StWrite;
        end
      end
      StWrite: begin
        if (rem_q == '0) begin
          state_d = StFinish;
        end else begin
          addr_d     = addr_q + ADDR_W'(1);
          pack_clear = 1'b1;
          state_d    = StCollect;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready  = out_en & (state_q == StIdle);
    st_ready   = out_en & (state_q == StCollect);
    chipselect = out_en & (state_q == StWrite);
    write      = out_en & (state_q == StWrite);
    busy       = out_en & (state_q != StIdle);
    done       = out_en & (state_q == StFinish);
    err        = out_en & err_q;
    address    = out_en ? addr_q : '0;
    writedata  = out_en ? pack_data : '0;
    byteenable = out_en ? pack_be : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      init_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Self-checking bench for onchip_mem_stream_loader against a word-list reference model.
module tb_onchip_mem_stream_loader;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_base = '0;
  logic [12:0] cmd_len = '0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [7:0]  st_data = '0;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = -1;
  int err_cyc = -1;
  int strobe_bad = 0;
  wr_t wr_q[$];
  logic [7:0] stim [0:63];

  onchip_mem_stream_loader dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_data    (st_data),
    .address    (address),
    .byteenable (byteenable),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorder of memory writes and status pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_t w;
      w.a = address; w.d = writedata; w.be = byteenable; w.cyc = cyc;
      wr_q.push_back(w);
    end
    if (write !== chipselect || (write === 1'b1 && (st_ready !== 1'b0 || cmd_ready !== 1'b0)))
      strobe_bad++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
  end

  // Tasks start and end at posedge+1.
  task automatic drive_cmd(input logic [9:0] b, input logic [12:0] l, output bit ok,
                           output int acc_cyc);
    bit acc = 0;
    int t = 0;
    cmd_valid = 1'b1; cmd_base = b; cmd_len = l;
    acc_cyc = -1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = cmd_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    ok = acc;
  endtask

  task automatic drive_bytes(input int n, input int gap_pct, output bit ok);
    ok = 1;
    for (int i = 0; i < n; i++) begin
      bit acc = 0;
      int t = 0;
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        st_valid = 1'b0; @(posedge clk); #1;
      end
      st_valid = 1'b1; st_data = stim[i];
      while (!acc && t < 50) begin
        @(negedge clk); acc = st_ready; @(posedge clk); #1; t++;
      end
      if (!acc) ok = 0;
    end
    st_valid = 1'b0; st_data = '0;
  endtask

  task automatic check_outputs_zero(input string name);
    logic [63:0] v;
    v = {cmd_ready, st_ready, address, byteenable, chipselect, write, writedata, busy, done, err};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs got %h want 0", name, v);
    end
  endtask

  task automatic run_load(input logic [9:0] b, input int l, input int gap_pct, input string name);
    wr_t exp_q[$];
    int w0 = wr_q.size(), d0 = done_cnt, e0 = err_cnt, s0 = strobe_bad;
    int acc_cyc, t = 0;
    bit ok, ok2;
    drive_cmd(b, 13'(l), ok, acc_cyc);
    drive_bytes(l, gap_pct, ok2);
    while (done_cnt == d0 && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    checks++;
    if (!(ok && ok2)) begin
      errors++; $display("FAIL %s handshake: got cmd=%0d st=%0d want 1 1", name, ok, ok2);
    end
    for (int k = 0; k < (l + 3) / 4; k++) begin
      wr_t e;
      int nb = (l - 4 * k < 4) ? l - 4 * k : 4;
      e.a = 10'(int'(b) + k); e.d = '0; e.be = '0;
      for (int j = 0; j < nb; j++) begin
        e.d[8*j +: 8] = stim[4*k + j];
        e.be[j] = 1'b1;
      end
      e.cyc = acc_cyc + 5 * k + nb + 1;
      exp_q.push_back(e);
    end
    checks++;
    if (wr_q.size() - w0 != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, wr_q.size() - w0, exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        wr_t g = wr_q[w0 + k];
        checks++;
        if (g.a !== exp_q[k].a || g.d !== exp_q[k].d || g.be !== exp_q[k].be) begin
          errors++;
          $display("FAIL %s write%0d: got a=%h d=%h be=%h want a=%h d=%h be=%h", name, k,
                   g.a, g.d, g.be, exp_q[k].a, exp_q[k].d, exp_q[k].be);
        end
        if (gap_pct == 0) begin
          checks++;
          if (g.cyc != exp_q[k].cyc) begin
            errors++;
            $display("FAIL %s write%0d_cycle: got %0d want %0d", name, k, g.cyc, exp_q[k].cyc);
          end
        end
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL %s pulses: got done=%0d err=%0d want 1 0", name, done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (exp_q.size() > 0 && done_cyc != wr_q[wr_q.size() - 1].cyc + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, wr_q[wr_q.size()-1].cyc + 1);
    end else if (exp_q.size() == 0 && done_cyc != acc_cyc + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, acc_cyc + 1);
    end
    checks++;
    if (strobe_bad != s0) begin
      errors++; $display("FAIL %s strobes: got %0d bad cycles want 0", name, strobe_bad - s0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_active");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_first_cycle");
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    for (int i = 0; i < 8; i++) stim[i] = 8'(8'h11 + i);
    run_load(10'h010, 8, 0, "full_word");
  endtask

  task automatic test_partial_tail();
    for (int i = 0; i < 6; i++) stim[i] = 8'(8'hA0 + i);
    run_load(10'h020, 6, 0, "partial_tail");
  endtask

  task automatic test_reject(input logic [9:0] b, input logic [12:0] l, input string name);
    int w0 = wr_q.size(), d0 = done_cnt, e0 = err_cnt, acc_cyc;
    bit ok, rdy_ok = 1;
    drive_cmd(b, l, ok, acc_cyc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || chipselect !== 1'b0) rdy_ok = 0;
    end
    @(posedge clk); #1;
    checks++;
    if (!ok || err_cnt - e0 != 1 || err_cyc != acc_cyc + 1) begin
      errors++;
      $display("FAIL %s err_pulse: got n=%0d cyc=%0d want 1 at %0d", name, err_cnt - e0, err_cyc,
               acc_cyc + 1);
    end
    checks++;
    if (wr_q.size() != w0 || done_cnt != d0 || !rdy_ok) begin
      errors++;
      $display("FAIL %s side_effects: got wr=%0d done=%0d rdy_ok=%0d want 0 0 1", name,
               wr_q.size() - w0, done_cnt - d0, rdy_ok);
    end
  endtask

  task automatic test_range();
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    run_load(10'h3FF, 4, 0, "range_top_word");
    test_reject(10'h3FF, 13'd5, "range_over_by_one");
    test_reject(10'h000, 13'd4097, "range_len_too_big");
  endtask

  task automatic test_zero_len();
    run_load(10'h155, 0, 0, "zero_len");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) stim[i] = 8'(8'h11 + i);
    run_load(10'h010, 8, 60, "stall_gaps");
  endtask

  task automatic test_reset_mid_load();
    int w0 = wr_q.size(), d0 = done_cnt, acc_cyc;
    bit ok;
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    drive_cmd(10'h040, 13'd8, ok, acc_cyc);
    drive_bytes(3, 0, ok);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midload_reset_active");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midload_reset_after");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_q.size() != w0 || done_cnt != d0) begin
      errors++;
      $display("FAIL midload_side_effects: got wr=%0d done=%0d want 0 0", wr_q.size() - w0,
               done_cnt - d0);
    end
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    run_load(10'h050, 8, 0, "after_reset_load");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int l = $urandom_range(40, 1);
      logic [9:0] b = 10'($urandom_range((4096 - l) / 4));
      for (int i = 0; i < l; i++) stim[i] = 8'($urandom);
      run_load(b, l, (n % 2 == 0) ? 0 : 30, "random_load");
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_tail();
    test_range();
    test_zero_len();
    test_stall();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_stream_loader.md
Name: onchip_mem_stream_loader

Overview:
- Upstream feeder for the 1024x32 single-port on-chip memory.
- Accepts a load command (base word address, byte length) and an 8-bit valid/ready byte stream.
- Packs bytes little-endian into 32-bit words and issues one-cycle Avalon-MM writes with byteenable.
- Used to preload or patch program/data RAM from a host byte channel without CPU involvement.

Parameters:
ADDR_W, 10, memory word-address width (depth = 2**ADDR_W words)
LEN_W, 13, byte-length field width (max 4096 bytes = full 1024-word memory)

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_base  in  ADDR_W  first word address
cmd_len  in  LEN_W  number of bytes to load
st_valid  in  1  stream byte offered
st_ready  out  1  stream byte taken when st_valid & st_ready
st_data  in  8  stream byte
address  out  ADDR_W  memory word address
byteenable  out  4  active byte lanes of current write
chipselect  out  1  memory select
write  out  1  memory write strobe
writedata  out  32  packed word
busy  out  1  command in progress
done  out  1  one-cycle pulse, load finished
err  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset is synchronous, active-high, and applies to the whole block. All outputs are 0 during reset and on the first cycle after it. State returns to IDLE. Any partial word is discarded, no write is issued, and done is not pulsed.
- FSM states: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - cmd_ready=1, st_ready=0, busy=0.
  - On accept with base*4+len > 4*2**ADDR_W: err pulses next cycle and the FSM stays IDLE.
  - On accept with len==0: go to FINISH; no writes.
  - Otherwise latch base into the address counter and len into the byte counter, clear lane buffer and byteenable, go to COLLECT.
- COLLECT:
  - st_ready=1.
  - Each accepted byte goes to lane k (k = lane index 0..3, lane 0 = writedata[7:0]), sets byteenable[k], and decrements the remaining count.
  - Go to WRITE on the cycle after the byte that fills lane 3 or makes remaining==0.
- WRITE (exactly one cycle):
  - chipselect=1, write=1, address/writedata/byteenable stable. st_ready=0.
  - The memory has no waitrequest and completes the write in this cycle.
  - Next state: if remaining==0, go to FINISH. Otherwise increment address, clear lanes and byteenable, return to COLLECT.
- Partial last word: only the collected lanes are enabled; unused writedata lanes are driven 0.
- FINISH: done=1 for one cycle, then IDLE.
- busy=1 in COLLECT, WRITE and FINISH.
- chipselect/write are 0 outside WRITE. address holds its last value when idle.
- Throughput: 5 cycles per full word; st_valid gaps stall COLLECT indefinitely.
- cmd_valid is ignored while busy; cmd_ready=0 while busy.
- Address never wraps, because range is checked at accept. base=1023 with len=4 is legal; len=5 is rejected.
- The memory's clken is tied high at top level.

Decomposition:
- Shared package holds the FSM state enum, the lane-count constant 4, and the byte-to-lane index helper.
- One natural sub-module: onchip_mem_byte_packer, which owns the lane buffer, byteenable accumulation and the full/last flag.

Test Plan:
- Full-word load: cmd base=0x010, len=8; bytes 0x11..0x18 -> two writes: addr 0x010 data 0x14131211 be=0xF, then addr 0x011 data 0x18171615 be=0xF; done 1 cycle after the second write.
- Partial tail: base=0x020, len=6, bytes 0xA0..0xA5 -> writes 0xA3A2A1A0 be=0xF at 0x020, then 0x0000A5A4 be=0x3 at 0x021.
- Range check: base=0x3FF, len=4 -> one write at 0x3FF. base=0x3FF, len=5 -> err pulse, no chipselect, cmd_ready stays 1.
- Zero length and stall: len=0 -> done without write. Random st_valid gaps on an 8-byte load -> identical write data and sequence, st_ready=0 during each WRITE.
- Reset mid-load: after 3 of 8 bytes assert reset for 1 cycle -> no write, no done, all outputs 0. A subsequent command completes correctly from the new base.
